s2mm_burst_writer: RTL and testbench
====================================

// Module: s2mm_burst_writer
// PURPOSE
//  Downstream consumer of the sync_manager S2MM command stream: a lightweight DataMover replacement.
//  Accepts one {ADDR,BTT} command at a time and drains sample data from an AXI-Stream.
//  Writes the data to DDR as aligned AXI4 INCR bursts, one burst outstanding.
//  Reports sticky error and a completed-buffer counter to the PS register map.
// PARAMETERS
//  MM_ADDR_WIDTH   32  AXI address width; command tdata width = MM_ADDR_WIDTH+40
//  DATA_WIDTH      64  AXI/AXIS data width in bits, power of two, 32..128
//  MAX_BURST_LEN   16  max beats per AXI burst, power of two, 1..256
// PORTS
//  SYS_aclk         in   1    single clock for all logic
//  SYS_reset        in   1    synchronous, active-high reset
//  S_AXIS_CMD_tvalid in  1    command valid
//  S_AXIS_CMD_tready out 1    high only in IDLE
//  S_AXIS_CMD_tdata  in  MM_ADDR_WIDTH+40  [ADDR@+32 .. 32]=ADDR, [22:0]=BTT in bytes, rest ignored
//  S_AXIS_tvalid/tready/tdata  in/out/in  1/1/DATA_WIDTH  sample stream (no tlast)
//  M_AXI_awaddr/awlen/awvalid/awready  out/out/out/in  MM_ADDR_WIDTH/8/1/1
//  M_AXI_awsize/awburst  out  3/2  constants: log2(DATA_WIDTH/8), 2'b01 INCR
//  M_AXI_wdata/wstrb/wlast/wvalid/wready  out/out/out/out/in  DATA_WIDTH/DATA_WIDTH/8/1/1/1
//  M_AXI_bresp/bvalid/bready  in/in/out  2/1/1
//  ST_busy          out  1    high from command accept to final B response
//  ST_error         out  1    sticky error flag
//  ST_done_count    out  32   number of fully completed commands, wraps at 2^32
// BEHAVIOUR
//  Reset: all valids, bready, ST_busy, ST_error low; ST_done_count 0; state IDLE; cmd tready 0 in reset cycle.
//  Reset mid-burst: abort immediately, all valids low the cycle after reset sampled; no completion counted.
//  FSM: IDLE -> CHECK -> ADDR -> DATA -> RESP -> (ADDR if beats remain else IDLE).
//  IDLE: tready=1; on tvalid&tready latch addr, beats = BTT >> log2(DATA_WIDTH/8).
//  CHECK (1 cycle): BTT==0, BTT not multiple of beat bytes, or addr not beat-aligned -> ST_error=1, IDLE, no AXI traffic.
//  ADDR: burst = min(remaining, MAX_BURST_LEN, beats to next 4 KiB boundary); awlen=burst-1;
//   awvalid held with stable awaddr/awlen until awready.
//  DATA: wvalid = S_AXIS_tvalid, S_AXIS_tready = wready (combinational pass-through, zero latency); wstrb all ones;
//   wlast on final beat of burst; W not issued before AW handshake.
//  RESP: bready=1; on bvalid: bresp!=2'b00 -> ST_error=1 (transfer continues); addr += burst*bytes, remaining -= burst.
//  Last B of a command: ST_done_count++ in same cycle as state -> IDLE; ST_busy drops the next cycle.
//  S_AXIS_tready low in every state except DATA; upstream stalls are absorbed by AXIS backpressure.
//  Max BTT 2^23-1 bytes -> remaining counter 23 bits; address arithmetic modulo 2^MM_ADDR_WIDTH.
//  Back-to-back commands: earliest new command accept is the cycle after IDLE is re-entered.
// STRUCTURE
//  Shared header vibrometer_defs.vh: command field offsets (BTT_LSB=0, BTT_W=23, TYPE_BIT=23, ADDR_LSB=32),
//   AXI constants (BURST_INCR, RESP_OKAY), log2 helper function.
//  One sub-module: s2mm_burst_calc (combinational): addr, remaining -> burst beats incl. 4 KiB split.
// TESTING
//  1 cmd ADDR=0x1000_0000, BTT=1024, DATA_WIDTH=64 -> 8 bursts awlen=15, 128 W beats, done_count=1, error=0.
//  2 ADDR=0x1000_0FC0, BTT=256 -> bursts of 8 beats (to 4 KiB edge) then 16, 8; no burst crosses 0x1000_1000.
//  3 BTT=0 and BTT=12 -> no AW issued, ST_error=1 after CHECK, cmd consumed, done_count unchanged.
//  4 random tvalid/wready/awready/bvalid gaps -> data order preserved, wlast every awlen+1 beats, no beat lost.
//  5 bresp=2'b10 on 2nd burst -> ST_error=1, remaining bursts still issued, done_count increments.
//  6 SYS_reset asserted mid-DATA -> next cycle awvalid=wvalid=bready=0, IDLE, new command completes normally.

Source files
------------

// File: rtl/s2mm_burst_writer_pkg.sv
// Shared definitions for the S2MM burst writer: command field offsets,
// AXI encodings, FSM state type and a constant log2 helper.
// Ports: none (package).
package s2mm_burst_writer_pkg;

   // Command word layout: {..., ADDR @ ADDR_LSB, ..., TYPE @ TYPE_BIT, BTT @ BTT_LSB}
   localparam int BTT_LSB  = 0;
   localparam int BTT_W    = 23;
   localparam int TYPE_BIT = 23;
   localparam int ADDR_LSB = 32;

   localparam logic [1:0] BURST_INCR = 2'b01;
   localparam logic [1:0] RESP_OKAY  = 2'b00;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CHECK,
      ST_ADDR,
      ST_DATA,
      ST_RESP
   } state_e;

   // Ceiling log2 for elaboration-time constants.
   function automatic int log2_f(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

endpackage

// File: rtl/s2mm_burst_calc.sv
// Purpose: beats for the next burst = min(remaining, MAX_BURST_LEN, beats to next 4 KiB page).
// Latency: purely combinational.
// Backpressure: none; inputs are held stable by the caller while the burst is requested.
// Ports: addr_lo (page offset of the current address), remaining (beats left), burst (beats).
module s2mm_burst_calc
   import s2mm_burst_writer_pkg::*;
#(
   parameter int DATA_WIDTH    = 64,
   parameter int MAX_BURST_LEN = 16,
   parameter int BURST_W       = log2_f(MAX_BURST_LEN) + 1
)(
   input  logic [11:0]        addr_lo,
   input  logic [BTT_W-1:0]   remaining,
   output logic [BURST_W-1:0] burst
);

   localparam int SHIFT = log2_f(DATA_WIDTH / 8);

   logic [12:0]      bytes_to_4k;
   logic [12:0]      beats_to_4k;
   logic [BTT_W-1:0] lim;

   // Address is beat aligned, so the byte distance divides exactly into beats.
   assign bytes_to_4k = 13'h1000 - {1'b0, addr_lo};
   assign beats_to_4k = bytes_to_4k >> SHIFT;

   always_comb begin
      lim = BTT_W'(MAX_BURST_LEN);
      if (BTT_W'(beats_to_4k) < lim) lim = BTT_W'(beats_to_4k);
      if (remaining < lim)           lim = remaining;
      burst = BURST_W'(lim);
   end

endmodule

// File: rtl/s2mm_burst_writer.sv
// Purpose: take one {ADDR,BTT} command, stream AXIS data to memory as aligned AXI4 INCR bursts.
// Latency: AW two cycles after command accept; W is a zero-latency pass-through of the stream.
// Backpressure: stream stalls via S_AXIS_tready = wready in DATA only; one burst outstanding.
// Ports: SYS_aclk/SYS_reset (sync, active high); S_AXIS_CMD_* command in; S_AXIS_* sample
//   stream in; M_AXI_aw*/w*/b* write channel out; ST_busy/ST_error/ST_done_count status out.
module s2mm_burst_writer
   import s2mm_burst_writer_pkg::*;
#(
   parameter int MM_ADDR_WIDTH = 32,
   parameter int DATA_WIDTH    = 64,
   parameter int MAX_BURST_LEN = 16
)(
   input  logic                       SYS_aclk,
   input  logic                       SYS_reset,
   input  logic                       S_AXIS_CMD_tvalid,
   output logic                       S_AXIS_CMD_tready,
   input  logic [MM_ADDR_WIDTH+39:0]  S_AXIS_CMD_tdata,
   input  logic                       S_AXIS_tvalid,
   output logic                       S_AXIS_tready,
   input  logic [DATA_WIDTH-1:0]      S_AXIS_tdata,
   output logic [MM_ADDR_WIDTH-1:0]   M_AXI_awaddr,
   output logic [7:0]                 M_AXI_awlen,
   output logic [2:0]                 M_AXI_awsize,
   output logic [1:0]                 M_AXI_awburst,
   output logic                       M_AXI_awvalid,
   input  logic                       M_AXI_awready,
   output logic [DATA_WIDTH-1:0]      M_AXI_wdata,
   output logic [DATA_WIDTH/8-1:0]    M_AXI_wstrb,
   output logic                       M_AXI_wlast,
   output logic                       M_AXI_wvalid,
   input  logic                       M_AXI_wready,
   input  logic [1:0]                 M_AXI_bresp,
   input  logic                       M_AXI_bvalid,
   output logic                       M_AXI_bready,
   output logic                       ST_busy,
   output logic                       ST_error,
   output logic [31:0]                ST_done_count
);

   localparam int SHIFT   = log2_f(DATA_WIDTH / 8);
   localparam int BURST_W = log2_f(MAX_BURST_LEN) + 1;

   state_e                   state_q, state_d;
   logic [MM_ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [BTT_W-1:0]         remaining_q, remaining_d;
   logic [BURST_W-1:0]       burst_q, burst_d;
   logic [BURST_W-1:0]       beat_q, beat_d;
   logic                     bad_q, bad_d;
   logic                     error_q, error_d;
   logic [31:0]              done_count_q, done_count_d;
   logic                     awvalid_q, awvalid_d;
   logic                     bready_q, bready_d;
   logic                     busy_q, busy_d;

   logic [MM_ADDR_WIDTH-1:0] cmd_addr;
   logic [BTT_W-1:0]         cmd_btt;
   logic                     cmd_hs;
   logic                     in_data;
   logic                     w_hs;
   logic                     last_beat;
   logic [BURST_W-1:0]       calc_burst;
   logic                     unused_cmd_bits;

   assign cmd_addr = S_AXIS_CMD_tdata[ADDR_LSB +: MM_ADDR_WIDTH];
   assign cmd_btt  = S_AXIS_CMD_tdata[BTT_LSB +: BTT_W];
   // Type bit and padding fields carry nothing this writer acts on.
   assign unused_cmd_bits = ^{S_AXIS_CMD_tdata[ADDR_LSB-1:TYPE_BIT],
                              S_AXIS_CMD_tdata[MM_ADDR_WIDTH+39:ADDR_LSB+MM_ADDR_WIDTH]};

   assign S_AXIS_CMD_tready = (state_q == ST_IDLE) && !SYS_reset;
   assign cmd_hs            = S_AXIS_CMD_tvalid && S_AXIS_CMD_tready;

   s2mm_burst_calc #(
      .DATA_WIDTH    (DATA_WIDTH),
      .MAX_BURST_LEN (MAX_BURST_LEN),
      .BURST_W       (BURST_W)
   ) u_calc (
      .addr_lo   (addr_q[11:0]),
      .remaining (remaining_q),
      .burst     (calc_burst)
   );

   // W channel is a straight wire to the stream while a burst is open.
   assign in_data       = (state_q == ST_DATA);
   assign M_AXI_wvalid  = in_data && S_AXIS_tvalid;
   assign S_AXIS_tready = in_data && M_AXI_wready;
   assign M_AXI_wdata   = S_AXIS_tdata;
   assign M_AXI_wstrb   = '1;
   assign w_hs          = M_AXI_wvalid && M_AXI_wready;
   assign last_beat     = (beat_q == burst_q - BURST_W'(1));
   assign M_AXI_wlast   = in_data && last_beat;

   // addr_q/remaining_q are frozen in ADDR, so awaddr/awlen stay stable until awready.
   assign M_AXI_awaddr  = addr_q;
   assign M_AXI_awlen   = 8'(calc_burst - BURST_W'(1));
   assign M_AXI_awsize  = 3'(SHIFT);
   assign M_AXI_awburst = BURST_INCR;
   assign M_AXI_awvalid = awvalid_q;
   assign M_AXI_bready  = bready_q;
   assign ST_busy       = busy_q;
   assign ST_error      = error_q;
   assign ST_done_count = done_count_q;

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      remaining_d  = remaining_q;
      burst_d      = burst_q;
      beat_d       = beat_q;
      bad_d        = bad_q;
      error_d      = error_q;
      done_count_d = done_count_q;
      case (state_q)
         ST_IDLE: begin
            if (cmd_hs) begin
               addr_d      = cmd_addr;
               remaining_d = cmd_btt >> SHIFT;
               bad_d       = (cmd_btt == '0) || (cmd_btt[SHIFT-1:0] != '0) ||
                             (cmd_addr[SHIFT-1:0] != '0);
               state_d     = ST_CHECK;
            end
         end
         ST_CHECK: begin
            if (bad_q) begin
               error_d = 1'b1;
               state_d = ST_IDLE;
            end else begin
               state_d = ST_ADDR;
            end
         end
         ST_ADDR: begin
            if (M_AXI_awready) begin
               burst_d = calc_burst;
               beat_d  = '0;
               state_d = ST_DATA;
            end
         end
         ST_DATA: begin
            if (w_hs) begin
               if (last_beat) state_d = ST_RESP;
               else           beat_d  = beat_q + BURST_W'(1);
            end
         end
         ST_RESP: begin
            if (M_AXI_bvalid) begin
               // A slave error is recorded but the buffer is still written out in full.
               if (M_AXI_bresp != RESP_OKAY) error_d = 1'b1;
               addr_d      = addr_q + (MM_ADDR_WIDTH'(burst_q) << SHIFT);
               remaining_d = remaining_q - BTT_W'(burst_q);
               if (remaining_q == BTT_W'(burst_q)) begin
                  done_count_d = done_count_q + 32'd1;
                  state_d      = ST_IDLE;
               end else begin
                  state_d = ST_ADDR;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
      awvalid_d = (state_d == ST_ADDR);
      bready_d  = (state_d == ST_RESP);
      busy_d    = (state_d != ST_IDLE);
   end

   always_ff @(posedge SYS_aclk) begin
      if (SYS_reset) begin
         state_q      <= ST_IDLE;
         addr_q       <= '0;
         remaining_q  <= '0;
         burst_q      <= '0;
         beat_q       <= '0;
         bad_q        <= 1'b0;
         error_q      <= 1'b0;
         done_count_q <= '0;
         awvalid_q    <= 1'b0;
         bready_q     <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         remaining_q  <= remaining_d;
         burst_q      <= burst_d;
         beat_q       <= beat_d;
         bad_q        <= bad_d;
         error_q      <= error_d;
         done_count_q <= done_count_d;
         awvalid_q    <= awvalid_d;
         bready_q     <= bready_d;
         busy_q       <= busy_d;
      end
   end

endmodule

// File: tb/tb_s2mm_burst_writer.sv
// Bench for s2mm_burst_writer: random stream/AW/W/B gaps, behavioural burst model,
// per-cycle output comparison on the falling edge, plus literal burst-shape expectations.
// Ports: none (top-level bench).
module tb_s2mm_burst_writer;

   logic        clk = 1'b0;
   logic        SYS_reset;
   logic        S_AXIS_CMD_tvalid;
   logic        S_AXIS_CMD_tready;
   logic [71:0] S_AXIS_CMD_tdata;
   logic        S_AXIS_tvalid;
   logic        S_AXIS_tready;
   logic [63:0] S_AXIS_tdata;
   logic [31:0] M_AXI_awaddr;
   logic [7:0]  M_AXI_awlen;
   logic [2:0]  M_AXI_awsize;
   logic [1:0]  M_AXI_awburst;
   logic        M_AXI_awvalid;
   logic        M_AXI_awready;
   logic [63:0] M_AXI_wdata;
   logic [7:0]  M_AXI_wstrb;
   logic        M_AXI_wlast;
   logic        M_AXI_wvalid;
   logic        M_AXI_wready;
   logic [1:0]  M_AXI_bresp;
   logic        M_AXI_bvalid;
   logic        M_AXI_bready;
   logic        ST_busy;
   logic        ST_error;
   logic [31:0] ST_done_count;

   s2mm_burst_writer dut (
      .SYS_aclk          (clk),
      .SYS_reset         (SYS_reset),
      .S_AXIS_CMD_tvalid (S_AXIS_CMD_tvalid),
      .S_AXIS_CMD_tready (S_AXIS_CMD_tready),
      .S_AXIS_CMD_tdata  (S_AXIS_CMD_tdata),
      .S_AXIS_tvalid     (S_AXIS_tvalid),
      .S_AXIS_tready     (S_AXIS_tready),
      .S_AXIS_tdata      (S_AXIS_tdata),
      .M_AXI_awaddr      (M_AXI_awaddr),
      .M_AXI_awlen       (M_AXI_awlen),
      .M_AXI_awsize      (M_AXI_awsize),
      .M_AXI_awburst     (M_AXI_awburst),
      .M_AXI_awvalid     (M_AXI_awvalid),
      .M_AXI_awready     (M_AXI_awready),
      .M_AXI_wdata       (M_AXI_wdata),
      .M_AXI_wstrb       (M_AXI_wstrb),
      .M_AXI_wlast       (M_AXI_wlast),
      .M_AXI_wvalid      (M_AXI_wvalid),
      .M_AXI_wready      (M_AXI_wready),
      .M_AXI_bresp       (M_AXI_bresp),
      .M_AXI_bvalid      (M_AXI_bvalid),
      .M_AXI_bready      (M_AXI_bready),
      .ST_busy           (ST_busy),
      .ST_error          (ST_error),
      .ST_done_count     (ST_done_count)
   );

   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;
   int p_gap  = 0;         // percent chance a ready/valid is held low in a cycle
   int err_burst = -1;     // index of the B response answered with SLVERR
   int b_issued = 0;

   // Reference model state
   logic [31:0] aw_addr_q[$];
   int          aw_len_q[$];
   int          aw_log[$];
   int          bursts_left = 0;
   int          cur_len = 0;
   int          w_beat = 0;
   int          w_idx = 0;
   int          w_total = 0;
   int          cmd_delay = 0;
   bit          cmd_bad = 1'b0;
   bit          aw_phase = 1'b0;
   bit          w_open = 1'b0;
   bit          b_phase = 1'b0;
   bit          exp_busy = 1'b0;
   bit          exp_err = 1'b0;
   logic [31:0] exp_done = '0;

   function automatic logic [63:0] word(input int i);
      logic [31:0] u;
      u = 32'(i);
      return {u ^ 32'hA5A5_5A5A, u * 32'h9E37_79B9};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      aw_addr_q.delete();
      aw_len_q.delete();
      bursts_left = 0;
      cmd_delay   = 0;
      aw_phase    = 1'b0;
      w_open      = 1'b0;
      b_phase     = 1'b0;
      exp_busy    = 1'b0;
      exp_err     = 1'b0;
      exp_done    = '0;
   endtask

   // Stream source: word(k) is the k-th sample accepted by the DUT.
   initial begin
      bit hs;
      int src_idx;
      src_idx = 0;
      S_AXIS_tvalid = 1'b0;
      S_AXIS_tdata  = word(0);
      forever begin
         @(negedge clk);
         hs = S_AXIS_tvalid && S_AXIS_tready && !SYS_reset;
         @(posedge clk); #1;
         if (hs) src_idx++;
         if (hs || !S_AXIS_tvalid) S_AXIS_tvalid = ($urandom_range(0, 99) >= p_gap);
         S_AXIS_tdata = word(src_idx);
      end
   end

   // AW / W slave readiness
   initial begin
      M_AXI_awready = 1'b0;
      M_AXI_wready  = 1'b0;
      forever begin
         @(posedge clk); #1;
         M_AXI_awready = ($urandom_range(0, 99) >= p_gap);
         M_AXI_wready  = ($urandom_range(0, 99) >= p_gap);
      end
   end

   // B responder: one response per completed burst, after a random delay.
   initial begin
      bit rst, bhs, wl;
      int pend;
      pend = 0;
      M_AXI_bvalid = 1'b0;
      M_AXI_bresp  = 2'b00;
      forever begin
         @(negedge clk);
         rst = SYS_reset;
         bhs = M_AXI_bvalid && M_AXI_bready;
         wl  = M_AXI_wvalid && M_AXI_wready && M_AXI_wlast;
         @(posedge clk); #1;
         if (rst) begin
            pend = 0;
            M_AXI_bvalid = 1'b0;
         end else begin
            if (wl) pend++;
            if (bhs) begin
               M_AXI_bvalid = 1'b0;
               pend--;
            end
            if (!M_AXI_bvalid && pend > 0 && $urandom_range(0, 99) >= p_gap) begin
               M_AXI_bvalid = 1'b1;
               M_AXI_bresp  = (b_issued == err_burst) ? 2'b10 : 2'b00;
               b_issued++;
            end
         end
      end
   end

   // Compare process: outputs against the model on every falling edge.
   initial begin
      logic [31:0] ca;
      int unsigned rb, to4k, b;
      forever begin
         @(negedge clk);
         if (SYS_reset) begin
            model_reset();
            continue;
         end
         if (cmd_delay > 0) begin
            cmd_delay--;
            if (cmd_delay == 0) begin
               if (cmd_bad) begin
                  exp_err  = 1'b1;
                  exp_busy = 1'b0;
               end else begin
                  aw_phase = 1'b1;
               end
            end
         end
         check("done_count", 64'(ST_done_count), 64'(exp_done));
         check("error", 64'(ST_error), 64'(exp_err));
         check("busy", 64'(ST_busy), 64'(exp_busy));
         check("cmd_tready", 64'(S_AXIS_CMD_tready), 64'(!exp_busy));
         check("awvalid", 64'(M_AXI_awvalid), 64'(aw_phase));
         check("wvalid", 64'(M_AXI_wvalid), 64'(w_open && S_AXIS_tvalid));
         check("s_tready", 64'(S_AXIS_tready), 64'(w_open && M_AXI_wready));
         check("bready", 64'(M_AXI_bready), 64'(b_phase));
         check("awsize", 64'(M_AXI_awsize), 64'd3);
         check("awburst", 64'(M_AXI_awburst), 64'd1);
         if (M_AXI_awvalid && aw_addr_q.size() > 0) begin
            check("awaddr", 64'(M_AXI_awaddr), 64'(aw_addr_q[0]));
            check("awlen", 64'(M_AXI_awlen), 64'(aw_len_q[0] - 1));
         end
         // W
         if (M_AXI_wvalid && M_AXI_wready) begin
            if (!w_open) begin
               check("w_without_aw", 64'(w_open), 64'd1);
            end else begin
               check("wdata", M_AXI_wdata, word(w_idx));
               check("wlast", 64'(M_AXI_wlast), 64'(w_beat == cur_len - 1));
               check("wstrb", 64'(M_AXI_wstrb), 64'hFF);
               w_idx++;
               w_total++;
               w_beat++;
               if (w_beat == cur_len) begin
                  w_open  = 1'b0;
                  b_phase = 1'b1;
               end
            end
         end
         // B
         if (M_AXI_bvalid && M_AXI_bready) begin
            b_phase = 1'b0;
            if (M_AXI_bresp != 2'b00) exp_err = 1'b1;
            bursts_left--;
            if (bursts_left <= 0) begin
               exp_done = exp_done + 32'd1;
               exp_busy = 1'b0;
            end else begin
               aw_phase = 1'b1;
            end
         end
         // AW
         if (M_AXI_awvalid && M_AXI_awready) begin
            aw_log.push_back(int'(M_AXI_awlen));
            if (aw_addr_q.size() == 0) begin
               check("aw_unexpected", 64'(aw_addr_q.size()), 64'd1);
            end else begin
               void'(aw_addr_q.pop_front());
               cur_len  = aw_len_q.pop_front();
               aw_phase = 1'b0;
               w_open   = 1'b1;
               w_beat   = 0;
            end
         end
         // Command accept: split the buffer into bursts with plain arithmetic.
         if (S_AXIS_CMD_tvalid && S_AXIS_CMD_tready) begin
            ca        = S_AXIS_CMD_tdata[63:32];
            rb        = 32'(S_AXIS_CMD_tdata[22:0]);
            cmd_bad   = (rb == 0) || (rb % 8 != 0) || (ca % 8 != 0);
            cmd_delay = 2;
            exp_busy  = 1'b1;
            aw_addr_q.delete();
            aw_len_q.delete();
            if (!cmd_bad) begin
               rb = rb / 8;
               while (rb > 0) begin
                  to4k = (4096 - (ca % 4096)) / 8;
                  b = rb;
                  if (b > 16) b = 16;
                  if (b > to4k) b = to4k;
                  aw_addr_q.push_back(ca);
                  aw_len_q.push_back(int'(b));
                  ca = ca + b * 8;
                  rb = rb - b;
               end
            end
            bursts_left = aw_len_q.size();
         end
      end
   end

   task automatic send_cmd(input logic [31:0] a, input logic [22:0] btt);
      bit ok;
      ok = 1'b0;
      @(posedge clk); #1;
      S_AXIS_CMD_tvalid = 1'b1;
      S_AXIS_CMD_tdata  = {8'($urandom), a, 9'($urandom), btt};
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (S_AXIS_CMD_tready) begin
            ok = 1'b1;
            break;
         end
      end
      @(posedge clk); #1;
      S_AXIS_CMD_tvalid = 1'b0;
      check("cmd_accept_timeout", 64'(ok), 64'd1);
   endtask

   task automatic wait_idle(input int limit);
      for (int i = 0; i < limit; i++) begin
         @(posedge clk);
         if (!exp_busy) break;
      end
      check("idle_timeout", 64'(exp_busy), 64'd0);
      @(negedge clk);
   endtask

   task automatic pulse_reset(input int cycles);
      @(posedge clk); #1;
      SYS_reset = 1'b1;
      repeat (cycles) @(posedge clk);
      #1 SYS_reset = 1'b0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] ra;
      logic [22:0] rbtt;
      int bound;
      SYS_reset         = 1'b1;
      S_AXIS_CMD_tvalid = 1'b0;
      S_AXIS_CMD_tdata  = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_cmd_tready", 64'(S_AXIS_CMD_tready), 64'd0);
      @(posedge clk); #1;
      SYS_reset = 1'b0;
      @(negedge clk);
      check("reset_awvalid", 64'(M_AXI_awvalid), 64'd0);
      check("reset_wvalid", 64'(M_AXI_wvalid), 64'd0);
      check("reset_bready", 64'(M_AXI_bready), 64'd0);
      check("reset_busy", 64'(ST_busy), 64'd0);
      check("reset_error", 64'(ST_error), 64'd0);
      check("reset_done", 64'(ST_done_count), 64'd0);

      // 1: aligned 1 KiB buffer -> 8 x 16-beat bursts
      aw_log.delete(); w_total = 0;
      send_cmd(32'h1000_0000, 23'd1024);
      wait_idle(3000);
      check("t1_nbursts", 64'(aw_log.size()), 64'd8);
      foreach (aw_log[i]) check("t1_awlen", 64'(aw_log[i]), 64'd15);
      check("t1_beats", 64'(w_total), 64'd128);
      check("t1_done", 64'(ST_done_count), 64'd1);
      check("t1_error", 64'(ST_error), 64'd0);
      check("t1_busy", 64'(ST_busy), 64'd0);

      // 2: start 64 bytes below a 4 KiB page -> 8, 16, 8 beats
      aw_log.delete(); w_total = 0;
      send_cmd(32'h1000_0FC0, 23'd256);
      wait_idle(3000);
      check("t2_nbursts", 64'(aw_log.size()), 64'd3);
      if (aw_log.size() == 3) begin
         check("t2_awlen0", 64'(aw_log[0]), 64'd7);
         check("t2_awlen1", 64'(aw_log[1]), 64'd15);
         check("t2_awlen2", 64'(aw_log[2]), 64'd7);
      end
      check("t2_beats", 64'(w_total), 64'd32);
      check("t2_done", 64'(ST_done_count), 64'd2);

      // 4: random gaps on every channel, random page-crossing buffers
      p_gap = 40;
      for (int i = 0; i < 8; i++) begin
         ra   = 32'h3000_0000 + 32'($urandom_range(0, 4095)) * 32'd8;
         rbtt = 23'($urandom_range(1, 256)) * 23'd8;
         send_cmd(ra, rbtt);
         wait_idle(8000);
      end
      check("t4_done", 64'(ST_done_count), 64'd10);
      check("t4_error", 64'(ST_error), 64'd0);

      // 5: SLVERR on the second burst; transfer still completes
      p_gap = 20;
      b_issued = 0; err_burst = 1;
      aw_log.delete(); w_total = 0;
      send_cmd(32'h4000_0000, 23'd512);
      wait_idle(4000);
      err_burst = -1;
      check("t5_error", 64'(ST_error), 64'd1);
      check("t5_done", 64'(ST_done_count), 64'd11);
      check("t5_nbursts", 64'(aw_log.size()), 64'd4);
      check("t5_beats", 64'(w_total), 64'd64);

      // 3: rejected commands -> error, no AW, no completion
      p_gap = 0;
      pulse_reset(2);
      @(negedge clk);
      check("t3_rst_done", 64'(ST_done_count), 64'd0);
      check("t3_rst_error", 64'(ST_error), 64'd0);
      aw_log.delete();
      send_cmd(32'h1000_0000, 23'd0);
      wait_idle(50);
      check("t3_btt0_error", 64'(ST_error), 64'd1);
      check("t3_btt0_done", 64'(ST_done_count), 64'd0);
      pulse_reset(1);
      send_cmd(32'h1000_0000, 23'd12);
      wait_idle(50);
      check("t3_btt12_error", 64'(ST_error), 64'd1);
      pulse_reset(1);
      send_cmd(32'h1000_0004, 23'd64);
      wait_idle(50);
      check("t3_misalign_error", 64'(ST_error), 64'd1);
      check("t3_misalign_done", 64'(ST_done_count), 64'd0);
      check("t3_no_aw", 64'(aw_log.size()), 64'd0);

      // 6: reset in the middle of a data phase
      pulse_reset(1);
      w_total = 0;
      send_cmd(32'h5000_0000, 23'd2048);
      bound = 0;
      while (w_total < 5 && bound < 500) begin
         @(posedge clk);
         bound++;
      end
      check("t6_reach_data", 64'(w_total >= 5), 64'd1);
      pulse_reset(1);
      @(negedge clk);
      check("t6_awvalid", 64'(M_AXI_awvalid), 64'd0);
      check("t6_wvalid", 64'(M_AXI_wvalid), 64'd0);
      check("t6_bready", 64'(M_AXI_bready), 64'd0);
      check("t6_busy", 64'(ST_busy), 64'd0);
      check("t6_done_after_rst", 64'(ST_done_count), 64'd0);
      aw_log.delete(); w_total = 0;
      send_cmd(32'h5000_0000, 23'd512);
      wait_idle(3000);
      check("t6_done", 64'(ST_done_count), 64'd1);
      check("t6_error", 64'(ST_error), 64'd0);
      check("t6_beats", 64'(w_total), 64'd64);

      repeat (5) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
